// File: rtl/delay_line_ctrl.sv
// Runtime-programmable delay line: circular buffer plus FILL/RUN/FLUSH controller.
// out holds real delayed data only once the buffer is primed for the active length.
module delay_line_ctrl #(
   parameter int MAX_LENGTH     = 16,
   parameter int WIDTH          = 8,
   parameter int DEFAULT_LENGTH = 4,
   parameter int LEN_W          = $clog2(MAX_LENGTH + 1)
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             ena,
   input  logic             flush,
   input  logic             len_wr,
   input  logic [LEN_W-1:0] len_req,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   output logic             busy,
   output logic [LEN_W-1:0] cur_len,
   output logic             cfg_err,
   output logic [1:0]       o_dbg_state
);

   localparam int PTR_W = $clog2(MAX_LENGTH);

   typedef enum logic [1:0] {
      S_FILL  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_next_state;
   logic [PTR_W-1:0]   r_wptr;
   logic [LEN_W-1:0]   r_fill_cnt;
   logic [WIDTH-1:0]   r_mem [MAX_LENGTH];

   logic               w_len_ok;
   logic               w_restart;
   logic               w_advance;
   logic               w_prime_done;
   logic [PTR_W-1:0]   w_rd_idx;
   logic [WIDTH-1:0]   w_rd_data;
   int                 w_sum;

   assign w_len_ok     = len_wr && (len_req != '0) && (len_req <= LEN_W'(MAX_LENGTH));
   assign w_restart    = w_len_ok || flush;
   assign w_advance    = ena && !w_restart && ((r_state == S_FILL) || (r_state == S_RUN));
   assign w_prime_done = (r_fill_cnt == (cur_len - 1'b1));
   assign busy         = (r_state == S_FLUSH);
   assign o_dbg_state  = r_state;

   // Oldest live entry: written cur_len-1 enabled edges before the current write slot.
   always_comb begin
      w_sum = int'(r_wptr) + MAX_LENGTH + 1 - int'(cur_len);
      if (w_sum >= MAX_LENGTH) begin
         w_sum = w_sum - MAX_LENGTH;
      end
      w_rd_idx  = PTR_W'(w_sum);
      w_rd_data = (cur_len == LEN_W'(1)) ? in : r_mem[w_rd_idx];
   end

   always_comb begin
      w_next_state = r_state;
      if (w_restart) begin
         w_next_state = S_FLUSH;
      end else begin
         case (r_state)
            S_FLUSH: w_next_state = S_FILL;
            S_FILL:  if (ena && w_prime_done) w_next_state = S_RUN;
            default: w_next_state = r_state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state    <= S_FILL;
         r_wptr     <= '0;
         r_fill_cnt <= '0;
         cur_len    <= LEN_W'(DEFAULT_LENGTH);
         out        <= '0;
         out_valid  <= 1'b0;
         cfg_err    <= 1'b0;
      end else begin
         r_state <= w_next_state;
         cfg_err <= len_wr && !w_len_ok;
         if (w_len_ok) begin
            cur_len <= len_req;
         end
         if (w_advance) begin
            r_wptr <= (r_wptr == PTR_W'(MAX_LENGTH - 1)) ? '0 : r_wptr + 1'b1;
         end
         if (w_restart || (r_state == S_FLUSH)) begin
            out        <= '0;
            out_valid  <= 1'b0;
            r_fill_cnt <= '0;
         end else if (ena && (r_state == S_FILL)) begin
            if (w_prime_done) begin
               out       <= w_rd_data;
               out_valid <= 1'b1;
            end else begin
               out        <= '0;
               r_fill_cnt <= r_fill_cnt + 1'b1;
            end
         end else if (ena && (r_state == S_RUN)) begin
            out <= w_rd_data;
         end
      end
   end

   // Buffer contents are deliberately left unreset; out is gated until priming completes.
   always_ff @(posedge clk) begin
      if (w_advance) begin
         r_mem[r_wptr] <= in;
      end
   end

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Directed bench for delay_line_ctrl: history-queue model checked every cycle plus literal pins.
module tb_delay_line_ctrl;

   localparam int MAX_LENGTH = 16;
   localparam int WIDTH      = 8;
   localparam int DEF_LEN    = 4;
   localparam int LEN_W      = $clog2(MAX_LENGTH + 1);

   logic             clk = 1'b0;
   logic             nrst;
   logic             ena;
   logic             flush;
   logic             len_wr;
   logic [LEN_W-1:0] len_req;
   logic [WIDTH-1:0] in_d;
   logic [WIDTH-1:0] out_d;
   logic             out_valid;
   logic             busy;
   logic [LEN_W-1:0] cur_len;
   logic             cfg_err;
   logic [1:0]       dbg_state;

   int n_checks = 0;
   int n_err    = 0;
   bit chk_en   = 1'b0;

   // Model: out is the in value from (len-1) enabled edges back, once len samples exist.
   logic [WIDTH-1:0] m_hist[$];
   int               m_len;
   logic [WIDTH-1:0] m_out;
   logic             m_valid;
   logic             m_busy;
   logic             m_cfg_err;

   delay_line_ctrl #(
      .MAX_LENGTH(MAX_LENGTH),
      .WIDTH(WIDTH),
      .DEFAULT_LENGTH(DEF_LEN)
   ) dut (
      .clk(clk),
      .nrst(nrst),
      .ena(ena),
      .flush(flush),
      .len_wr(len_wr),
      .len_req(len_req),
      .in(in_d),
      .out(out_d),
      .out_valid(out_valid),
      .busy(busy),
      .cur_len(cur_len),
      .cfg_err(cfg_err),
      .o_dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_hist.delete();
      m_len     = DEF_LEN;
      m_out     = '0;
      m_valid   = 1'b0;
      m_busy    = 1'b0;
      m_cfg_err = 1'b0;
   endtask

   task automatic model_edge(input logic en, input logic fl, input logic lw,
                             input logic [LEN_W-1:0] lr, input logic [WIDTH-1:0] din);
      logic legal;
      legal     = lw && (int'(lr) >= 1) && (int'(lr) <= MAX_LENGTH);
      m_cfg_err = lw && !legal;
      if (legal) m_len = int'(lr);
      if (legal || fl) begin
         m_busy  = 1'b1;
         m_hist.delete();
         m_out   = '0;
         m_valid = 1'b0;
      end else if (m_busy) begin
         m_busy  = 1'b0;
         m_out   = '0;
         m_valid = 1'b0;
      end else if (en) begin
         m_hist.push_back(din);
         if (m_hist.size() >= m_len) begin
            m_out   = m_hist[m_hist.size() - m_len];
            m_valid = 1'b1;
         end else begin
            m_out = '0;
         end
         if (m_hist.size() > 2 * MAX_LENGTH) void'(m_hist.pop_front());
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("out", 32'(out_d), 32'(m_out));
         check("out_valid", 32'(out_valid), 32'(m_valid));
         check("busy", 32'(busy), 32'(m_busy));
         check("cur_len", 32'(cur_len), 32'(m_len));
         check("cfg_err", 32'(cfg_err), 32'(m_cfg_err));
      end
   end

   task automatic cycle(input logic en, input logic fl, input logic lw,
                        input logic [LEN_W-1:0] lr, input logic [WIDTH-1:0] din);
      ena = en; flush = fl; len_wr = lw; len_req = lr; in_d = din;
      @(posedge clk);
      model_edge(en, fl, lw, lr, din);
      @(negedge clk);
      #1;
   endtask

   task automatic async_reset(input string tag);
      ena = 1'b0; flush = 1'b0; len_wr = 1'b0; len_req = '0;
      @(posedge clk);
      model_edge(1'b0, 1'b0, 1'b0, '0, '0);
      #2;
      nrst = 1'b0;
      model_reset();
      #1;
      check({tag, "_out"}, 32'(out_d), 32'd0);
      check({tag, "_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_cur_len"}, 32'(cur_len), 32'(DEF_LEN));
      @(negedge clk);
      #1;
      nrst = 1'b1;
   endtask

   initial begin
      nrst = 1'b0; ena = 1'b0; flush = 1'b0; len_wr = 1'b0; len_req = '0; in_d = '0;
      model_reset();
      chk_en = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("reset_out", 32'(out_d), 32'd0);
      check("reset_valid", 32'(out_valid), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_cur_len", 32'(cur_len), 32'd4);
      check("reset_cfg_err", 32'(cfg_err), 32'd0);
      nrst = 1'b1;

      // Priming with the default length and a counting input
      for (int k = 1; k <= 10; k++) begin
         cycle(1'b1, 1'b0, 1'b0, '0, 8'(k));
         if (k == 3) check("prime_valid_e3", 32'(out_valid), 32'd0);
         if (k == 4) check("prime_out_e4", 32'(out_d), 32'd1);
         if (k == 4) check("prime_valid_e4", 32'(out_valid), 32'd1);
         if (k == 10) check("prime_out_e10", 32'(out_d), 32'd7);
      end

      // Flush completes in one clock even with ena low, then ena toggles
      cycle(1'b1, 1'b1, 1'b0, '0, 8'd0);
      check("flush_busy", 32'(busy), 32'd1);
      cycle(1'b0, 1'b0, 1'b0, '0, 8'd0);
      check("flush_done", 32'(busy), 32'd0);
      for (int i = 0; i < 16; i++) begin
         cycle((i % 2) == 0, 1'b0, 1'b0, '0, 8'(100 + i));
         if (i == 5) check("toggle_valid_i5", 32'(out_valid), 32'd0);
         if (i == 6) check("toggle_out_i6", 32'(out_d), 32'd100);
         if (i == 7) check("toggle_hold_i7", 32'(out_d), 32'd100);
      end

      // Length 1: bypass path
      cycle(1'b1, 1'b0, 1'b1, 5'd1, 8'd55);
      check("len1_busy", 32'(busy), 32'd1);
      check("len1_out_zero", 32'(out_d), 32'd0);
      cycle(1'b1, 1'b0, 1'b0, '0, 8'd66);
      cycle(1'b1, 1'b0, 1'b0, '0, 8'd77);
      check("len1_out", 32'(out_d), 32'd77);
      check("len1_cur_len", 32'(cur_len), 32'd1);
      cycle(1'b1, 1'b0, 1'b0, '0, 8'd78);

      // Illegal lengths
      cycle(1'b0, 1'b0, 1'b1, 5'd0, 8'd9);
      check("bad0_cfg_err", 32'(cfg_err), 32'd1);
      check("bad0_out", 32'(out_d), 32'd78);
      cycle(1'b0, 1'b0, 1'b1, 5'd17, 8'd9);
      check("bad17_cfg_err", 32'(cfg_err), 32'd1);
      check("bad17_cur_len", 32'(cur_len), 32'd1);
      cycle(1'b0, 1'b0, 1'b0, '0, 8'd0);
      check("cfg_err_pulse", 32'(cfg_err), 32'd0);
      cycle(1'b1, 1'b1, 1'b1, 5'd0, 8'd3);
      check("bad_flush_err", 32'(cfg_err), 32'd1);
      check("bad_flush_busy", 32'(busy), 32'd1);
      cycle(1'b1, 1'b0, 1'b0, '0, 8'd0);

      // Maximum length across several pointer wraps
      cycle(1'b1, 1'b0, 1'b1, 5'd16, 8'd0);
      cycle(1'b1, 1'b0, 1'b0, '0, 8'd0);
      for (int i = 0; i < 70; i++) begin
         cycle($urandom_range(0, 3) != 0, 1'b0, 1'b0, '0, 8'($urandom_range(0, 255)));
      end

      // Async reset mid-FILL and mid-RUN
      cycle(1'b1, 1'b1, 1'b0, '0, 8'd0);
      cycle(1'b1, 1'b0, 1'b0, '0, 8'd0);
      cycle(1'b1, 1'b0, 1'b0, '0, 8'd21);
      cycle(1'b1, 1'b0, 1'b0, '0, 8'd22);
      async_reset("rst_fill");
      for (int k = 1; k <= 6; k++) cycle(1'b1, 1'b0, 1'b0, '0, 8'(40 + k));
      async_reset("rst_run");
      for (int k = 1; k <= 4; k++) begin
         cycle(1'b1, 1'b0, 1'b0, '0, 8'(60 + k));
         if (k == 3) check("refill_valid_e3", 32'(out_valid), 32'd0);
         if (k == 4) check("refill_out_e4", 32'(out_d), 32'd61);
      end

      // Flush + len 7 together, then len 3 while flushing
      cycle(1'b1, 1'b1, 1'b1, 5'd7, 8'd5);
      check("dbl_busy1", 32'(busy), 32'd1);
      check("dbl_len7", 32'(cur_len), 32'd7);
      cycle(1'b1, 1'b0, 1'b1, 5'd3, 8'd6);
      check("dbl_busy2", 32'(busy), 32'd1);
      check("dbl_len3", 32'(cur_len), 32'd3);
      cycle(1'b1, 1'b0, 1'b0, '0, 8'd0);
      check("dbl_busy_end", 32'(busy), 32'd0);
      cycle(1'b1, 1'b0, 1'b0, '0, 8'd10);
      cycle(1'b1, 1'b0, 1'b0, '0, 8'd11);
      check("dbl_valid_e2", 32'(out_valid), 32'd0);
      cycle(1'b1, 1'b0, 1'b0, '0, 8'd12);
      check("dbl_valid_e3", 32'(out_valid), 32'd1);
      check("dbl_out_e3", 32'(out_d), 32'd10);
      cycle(1'b1, 1'b0, 1'b0, '0, 8'd13);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
